instruction_encoder_loader: RTL and testbench

//  Inverse of the control-unit decode path. Packs data-processing instruction fields into 32-bit words and writes them into instruction RAM via MAR/MDR with an mfc handshake.

---
 rtl/instruction_encoder_loader.sv | 109 ++++++++++
 tb/tb_instruction_encoder_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder_loader.sv
// Packs data-processing instruction fields into 32-bit words and writes them to instruction RAM
// over MAR/MDR with an mfc handshake. Optional feature macro: COND_FIELD_EN.
module instruction_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              format,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [3:0]        ra,
    input  logic [3:0]        rc,
    input  logic [3:0]        rb,
    input  logic [1:0]        shift,
    input  logic [4:0]        shift_imm,
    input  logic [3:0]        rotate_imm,
    input  logic [7:0]        immediate,
    input  logic [3:0]        cond,
    output logic [ADDR_W-1:0] mar,
    output logic [31:0]       mdr,
    output logic              ram_en,
    output logic              rw,
    input  logic              mfc,
    input  logic              err_clr,
    output logic              err,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [3:0]       cond_bits;
    logic [31:0]      word;

`ifdef COND_FIELD_EN
    assign cond_bits = cond;
`else
    // Condition field hard-wired to "always"; the cond port is intentionally ignored.
    logic unused_cond;
    assign unused_cond = ^cond;
    assign cond_bits   = 4'hE;
`endif

    always_comb begin
        word = '0;
        if (format) begin
            word = {cond_bits, 3'b001, opcode, s_bit, ra, rc, rotate_imm, immediate};
        end else begin
            word = {cond_bits, 3'b000, opcode, s_bit, ra, rc, shift_imm, shift, 1'b0, rb};
        end
    end

    assign in_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
            mar       <= ADDR_W'(BASE_ADDR);
            mdr       <= '0;
            ram_en    <= 1'b0;
            rw        <= 1'b0;
            err       <= 1'b0;
            wr_count  <= '0;
        end else begin
            // A timeout on the same edge overrides the clear below.
            if (err_clr) begin
                err <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mdr       <= word;
                        ram_en    <= 1'b1;
                        rw        <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Completion wins over a timeout expiring on the same edge.
                    if (mfc) begin
                        ram_en   <= 1'b0;
                        rw       <= 1'b0;
                        mar      <= mar + ADDR_W'(4);
                        wr_count <= wr_count + ADDR_W'(1);
                        state_q  <= StIdle;
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        ram_en  <= 1'b0;
                        rw      <= 1'b0;
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench for instruction_encoder_loader: scoreboard of expected (address, word)
// pairs popped whenever the DUT completes a RAM write.
module tb_instruction_encoder_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] word;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              format;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [3:0]        ra;
    logic [3:0]        rc;
    logic [3:0]        rb;
    logic [1:0]        shift;
    logic [4:0]        shift_imm;
    logic [3:0]        rotate_imm;
    logic [7:0]        immediate;
    logic [3:0]        cond;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       mdr;
    logic              ram_en;
    logic              rw;
    logic              mfc;
    logic              err_clr;
    logic              err;
    logic [ADDR_W-1:0] wr_count;

    sb_t         sb[$];
    sb_t         sb_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [7:0]  exp_mar;
    logic [7:0]  exp_cnt;
    logic [31:0] w;
    int          cyc0;

    instruction_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .format    (format),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .ra        (ra),
        .rc        (rc),
        .rb        (rb),
        .shift     (shift),
        .shift_imm (shift_imm),
        .rotate_imm(rotate_imm),
        .immediate (immediate),
        .cond      (cond),
        .mar       (mar),
        .mdr       (mdr),
        .ram_en    (ram_en),
        .rw        (rw),
        .mfc       (mfc),
        .err_clr   (err_clr),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected encoding built bit-by-bit from the currently driven fields.
    function automatic logic [31:0] enc_now();
        logic [31:0] v;
        v = (32'(opcode) << 21) | (32'(s_bit) << 20) | (32'(ra) << 16) | (32'(rc) << 12);
        if (format) v = v | 32'h0200_0000 | (32'(rotate_imm) << 8) | 32'(immediate);
        else        v = v | (32'(shift_imm) << 7) | (32'(shift) << 5) | 32'(rb);
`ifdef COND_FIELD_EN
        v = v | (32'(cond) << 28);
`else
        v = v | 32'hE000_0000;
`endif
        return v;
    endfunction

    task automatic set_fields(input logic fmt, input logic [3:0] opc, input logic s,
                              input logic [3:0] a, input logic [3:0] c, input logic [3:0] b,
                              input logic [1:0] sh, input logic [4:0] shi,
                              input logic [3:0] rot, input logic [7:0] imm,
                              input logic [3:0] cnd);
        format = fmt; opcode = opc; s_bit = s; ra = a; rc = c; rb = b;
        shift = sh; shift_imm = shi; rotate_imm = rot; immediate = imm; cond = cnd;
    endtask

    task automatic scramble();
        set_fields(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 2'($urandom), 5'($urandom), 4'($urandom), 8'($urandom),
                   4'($urandom));
    endtask

    // One successful write; mfc is seen on the delay-th WAIT edge.
    task automatic write_word(input int delay, input logic [31:0] exp_word);
        sb_t e;
        int  hi;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        e.addr = exp_mar;
        e.word = exp_word;
        sb.push_back(e);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("mdr_capture", mdr, exp_word);
        scramble();
        hi = 0;
        for (int k = 1; k <= delay; k++) begin
            mfc = (k == delay);
            @(negedge clk);
            if (ram_en && rw && !in_ready) hi++;
            @(posedge clk); #1;
            mfc = 1'b0;
        end
        exp_mar = exp_mar + 8'd4;
        exp_cnt = exp_cnt + 8'd1;
        check_eq("ram_en_cycles", 32'(hi), 32'(delay));
        check_eq("ram_en_done", 32'(ram_en), 32'd0);
        check_eq("rw_done", 32'(rw), 32'd0);
        check_eq("mar_after", 32'(mar), 32'(exp_mar));
        check_eq("wr_count_after", 32'(wr_count), 32'(exp_cnt));
    endtask

    // A write that never sees mfc; optionally pulses err_clr on the expiry edge.
    task automatic write_timeout(input logic clr_on_expiry, input logic [31:0] exp_word);
        int hi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("to_mdr", mdr, exp_word);
        hi = 0;
        for (int k = 1; k <= int'(TIMEOUT) + 5; k++) begin
            err_clr = clr_on_expiry && (k == int'(TIMEOUT));
            @(negedge clk);
            if (!ram_en) break;
            hi++;
            @(posedge clk); #1;
            err_clr = 1'b0;
        end
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_eq("to_cycles", 32'(hi), 32'(TIMEOUT));
        check_eq("to_ram_en", 32'(ram_en), 32'd0);
        check_eq("to_rw", 32'(rw), 32'd0);
        check_eq("to_err", 32'(err), 32'd1);
        check_eq("to_mar", 32'(mar), 32'(exp_mar));
        check_eq("to_wr_count", 32'(wr_count), 32'(exp_cnt));
        check_eq("to_in_ready", 32'(in_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset_n && ram_en && mfc) begin
            check_eq("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                check_eq("wr_mar", 32'(mar), 32'(sb_e.addr));
                check_eq("wr_mdr", mdr, sb_e.word);
                check_eq("wr_rw", 32'(rw), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; mfc = 1'b0; err_clr = 1'b0;
        set_fields(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 2'h0, 5'h0, 4'h0, 8'h00, 4'h0);
        exp_mar = 8'd0;
        exp_cnt = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_mar", 32'(mar), 32'd0);
        check_eq("rst_mdr", mdr, 32'd0);
        check_eq("rst_ram_en", 32'(ram_en), 32'd0);
        check_eq("rst_rw", 32'(rw), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Immediate format, mfc on third WAIT edge.
        set_fields(1'b1, 4'd4, 1'b0, 4'd1, 4'd2, 4'd0, 2'd0, 5'd0, 4'd0, 8'h05, 4'h7);
`ifdef COND_FIELD_EN
        write_word(3, 32'h72812005);
`else
        write_word(3, 32'hE2812005);
`endif

        // Register format, back-to-back with immediate mfc: 2 cycles per word.
        cyc0 = cyc;
        set_fields(1'b0, 4'd4, 1'b0, 4'd1, 4'd3, 4'd2, 2'd0, 5'd2, 4'd0, 8'h00, 4'hE);
        write_word(1, 32'hE0813102);
        set_fields(1'b0, 4'd4, 1'b0, 4'd1, 4'd3, 4'd2, 2'd0, 5'd2, 4'd0, 8'h00, 4'hE);
        write_word(1, 32'hE0813102);
        check_eq("b2b_cycles", 32'(cyc - cyc0), 32'd4);

        // mfc high while idle must do nothing.
        mfc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mfc = 1'b0;
        check_eq("idle_mfc_ram_en", 32'(ram_en), 32'd0);
        check_eq("idle_mfc_mar", 32'(mar), 32'(exp_mar));
        check_eq("idle_mfc_wr_count", 32'(wr_count), 32'(exp_cnt));

        // mfc on the same edge the timeout expires counts as a completed write.
        scramble();
        write_word(int'(TIMEOUT), enc_now());
        check_eq("late_mfc_err", 32'(err), 32'd0);

        // Timeout with err_clr on the expiry edge: err must stay set.
        scramble();
        w = enc_now();
        write_timeout(1'b1, w);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_eq("err_cleared", 32'(err), 32'd0);

        // Retry with identical fields goes to the same address.
        write_word(2, w);

        // Leave err set, then reset in the middle of a WAIT.
        scramble();
        write_timeout(1'b0, enc_now());
        scramble();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("pre_rst_ram_en", 32'(ram_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ram_en", 32'(ram_en), 32'd0);
        check_eq("mid_rst_rw", 32'(rw), 32'd0);
        check_eq("mid_rst_mar", 32'(mar), 32'd0);
        check_eq("mid_rst_mdr", mdr, 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_wr_count", 32'(wr_count), 32'd0);
        exp_mar = 8'd0;
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 64 writes wrap the pointer back to zero.
        for (int i = 0; i < 64; i++) begin
            scramble();
            write_word(1, enc_now());
        end
        check_eq("wrap_mar", 32'(mar), 32'd0);
        check_eq("wrap_wr_count", 32'(wr_count), 32'd64);

        // Condition field source.
        set_fields(1'b1, 4'd4, 1'b0, 4'd1, 4'd2, 4'd0, 2'd0, 5'd0, 4'd0, 8'h05, 4'h0);
`ifdef COND_FIELD_EN
        write_word(1, 32'h02812005);
`else
        write_word(1, 32'hE2812005);
`endif
        scramble();
        cond = 4'h9;
        write_word(2, enc_now());

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
